// File: rtl/keccak_pkg.sv
// Shared types and constants for the keccak sponge arbiter slice.
package keccak_pkg;

   typedef enum logic [2:0] {
      ARB_IDLE  = 3'd0,
      ARB_CLEAR = 3'd1,
      ARB_WAIT  = 3'd2,
      ARB_OWNED = 3'd3,
      ARB_DRAIN = 3'd4
   } arb_state_t;

   // Rate in 64-bit lanes (r/64) for the supported sponge modes.
   localparam logic [4:0] RATE_SHAKE128 = 5'd21;
   localparam logic [4:0] RATE_SHAKE256 = 5'd17;
   localparam logic [4:0] RATE_SHA3_256 = 5'd17;
   localparam logic [4:0] RATE_SHA3_512 = 5'd9;

endpackage

// File: rtl/keccak_sponge_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W:0]   pos;
   logic [IDX_W-1:0] cand;
   logic             found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      cand  = '0;
      for (int k = 0; k < N; k++) begin
         pos = {1'b0, ptr} + (IDX_W+1)'(k);
         if (pos >= (IDX_W+1)'(N)) pos = pos - (IDX_W+1)'(N);
         cand = pos[IDX_W-1:0];
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

// File: rtl/keccak_sponge_arbiter.sv
// Round-robin owner arbitration for one shared keccak sponge, with a reset pulse per owner.
// Optional idle watchdog enabled by defining KECCAK_ARB_TIMEOUT_EN.
module keccak_sponge_arbiter
   import keccak_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int IDX_W          = $clog2(NUM_REQ),
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ-1:0]    req_release,
   input  logic [NUM_REQ*5-1:0]  req_rate_words,
   output logic [NUM_REQ-1:0]    grant,
   output logic [IDX_W-1:0]      grant_idx,
   input  logic [NUM_REQ-1:0]    rq_absorb_valid,
   input  logic [NUM_REQ*64-1:0] rq_absorb_data,
   input  logic [NUM_REQ-1:0]    rq_absorb_last,
   output logic [NUM_REQ-1:0]    rq_absorb_ready,
   output logic [NUM_REQ-1:0]    rq_squeeze_valid,
   output logic [63:0]           rq_squeeze_data,
   input  logic [NUM_REQ-1:0]    rq_squeeze_ready,
   output logic                  sp_rst_n,
   output logic [4:0]            sp_rate_words,
   output logic                  sp_absorb_valid,
   output logic [63:0]           sp_absorb_data,
   output logic                  sp_absorb_last,
   input  logic                  sp_absorb_ready,
   input  logic                  sp_squeeze_valid,
   input  logic [63:0]           sp_squeeze_data,
   output logic                  sp_squeeze_ready,
   input  logic                  sp_busy,
`ifdef KECCAK_ARB_TIMEOUT_EN
   output logic                  timeout_evt,
`endif
   output logic [2:0]            dbg_state,
   output logic [IDX_W-1:0]      dbg_ptr
);

   arb_state_t       state_q, state_d;
   logic [IDX_W-1:0] owner_q, owner_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             sp_rst_n_q, sp_rst_n_d;
   logic [NUM_REQ-1:0] pick_gnt;
   logic [IDX_W-1:0]   pick_idx;
   logic owned, release_hit, fire;

   rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx)
   );

   assign owned       = (state_q == ARB_OWNED);
   assign release_hit = owned && req_release[owner_q];

   // Owner <-> sponge routing is purely combinational so streams see no extra latency.
   always_comb begin
      grant            = '0;
      rq_absorb_ready  = '0;
      rq_squeeze_valid = '0;
      sp_rate_words    = '0;
      sp_absorb_valid  = 1'b0;
      sp_absorb_data   = '0;
      sp_absorb_last   = 1'b0;
      sp_squeeze_ready = 1'b0;
      if (owned) begin
         grant[owner_q]            = 1'b1;
         rq_absorb_ready[owner_q]  = sp_absorb_ready;
         rq_squeeze_valid[owner_q] = sp_squeeze_valid;
         sp_rate_words             = req_rate_words[int'(owner_q)*5 +: 5];
         sp_absorb_valid           = rq_absorb_valid[owner_q];
         sp_absorb_data            = rq_absorb_data[int'(owner_q)*64 +: 64];
         sp_absorb_last            = rq_absorb_last[owner_q];
         sp_squeeze_ready          = rq_squeeze_ready[owner_q];
      end
   end

   assign rq_squeeze_data = sp_squeeze_data;
   assign grant_idx       = owner_q;
   assign sp_rst_n        = sp_rst_n_q;
   assign dbg_state       = state_q;
   assign dbg_ptr         = ptr_q;

   // sp_rst_n_d tracks the next state so the sponge reset is low exactly while in CLEAR.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      ptr_d      = ptr_q;
      sp_rst_n_d = 1'b1;
      case (state_q)
         ARB_IDLE: begin
            if (|pick_gnt) begin
               owner_d    = pick_idx;
               ptr_d      = (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
               state_d    = ARB_CLEAR;
               sp_rst_n_d = 1'b0;
            end
         end
         ARB_CLEAR: state_d = ARB_WAIT;
         ARB_WAIT:  if (sp_absorb_ready) state_d = ARB_OWNED;
         ARB_OWNED: if (release_hit || fire) state_d = ARB_DRAIN;
         ARB_DRAIN: if (!sp_busy) state_d = ARB_IDLE;
         default:   state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB_IDLE;
         owner_q    <= '0;
         ptr_q      <= '0;
         sp_rst_n_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         ptr_q      <= ptr_d;
         sp_rst_n_q <= sp_rst_n_d;
      end
   end

`ifdef KECCAK_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
   logic             handshake;

   assign handshake = (sp_absorb_valid && sp_absorb_ready) ||
                      (sp_squeeze_valid && sp_squeeze_ready);

   // Counter is zero outside OWNED, so entry to OWNED always starts from a clean count.
   always_comb begin
      idle_cnt_d = '0;
      fire       = 1'b0;
      if (owned && !handshake) begin
         idle_cnt_d = idle_cnt_q + 1'b1;
         fire       = (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) idle_cnt_q <= '0;
      else     idle_cnt_q <= idle_cnt_d;
   end

   assign timeout_evt = fire;
`else
   assign fire = 1'b0;
`endif

endmodule

// File: tb/tb_keccak_sponge_arbiter.sv
// Directed bench for keccak_sponge_arbiter against a toy sponge (XOR accumulator, digest = acc ^ rate).
module tb_keccak_sponge_arbiter;
   import keccak_pkg::*;

   localparam int NR = 4;
   localparam int IW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [NR-1:0]  req_valid, req_release, grant;
   logic [NR*5-1:0] req_rate_words;
   logic [IW-1:0]  grant_idx, dbg_ptr;
   logic [NR-1:0]  rq_absorb_valid, rq_absorb_last, rq_absorb_ready;
   logic [NR*64-1:0] rq_absorb_data;
   logic [NR-1:0]  rq_squeeze_valid, rq_squeeze_ready;
   logic [63:0]    rq_squeeze_data;
   logic           sp_rst_n, sp_absorb_valid, sp_absorb_last, sp_absorb_ready;
   logic [4:0]     sp_rate_words;
   logic [63:0]    sp_absorb_data, sp_squeeze_data;
   logic           sp_squeeze_valid, sp_squeeze_ready, sp_busy;
   logic [2:0]     dbg_state;
`ifdef KECCAK_ARB_TIMEOUT_EN
   logic           timeout_evt;
`endif

   int n_total = 0;
   int n_bad   = 0;
   logic mon_en = 1'b0;

   always #5 clk = ~clk;

   keccak_sponge_arbiter #(.NUM_REQ(NR), .IDX_W(IW), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_release(req_release), .req_rate_words(req_rate_words),
      .grant(grant), .grant_idx(grant_idx),
      .rq_absorb_valid(rq_absorb_valid), .rq_absorb_data(rq_absorb_data),
      .rq_absorb_last(rq_absorb_last), .rq_absorb_ready(rq_absorb_ready),
      .rq_squeeze_valid(rq_squeeze_valid), .rq_squeeze_data(rq_squeeze_data),
      .rq_squeeze_ready(rq_squeeze_ready),
      .sp_rst_n(sp_rst_n), .sp_rate_words(sp_rate_words),
      .sp_absorb_valid(sp_absorb_valid), .sp_absorb_data(sp_absorb_data),
      .sp_absorb_last(sp_absorb_last), .sp_absorb_ready(sp_absorb_ready),
      .sp_squeeze_valid(sp_squeeze_valid), .sp_squeeze_data(sp_squeeze_data),
      .sp_squeeze_ready(sp_squeeze_ready), .sp_busy(sp_busy),
`ifdef KECCAK_ARB_TIMEOUT_EN
      .timeout_evt(timeout_evt),
`endif
      .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
   );

   // Toy sponge: async active-low reset, ready one cycle after reset release.
   logic        mdl_rdy_q, mdl_sq_q;
   logic [63:0] mdl_acc_q;
   logic        busy_force;

   always_ff @(posedge clk or negedge sp_rst_n) begin
      if (!sp_rst_n) begin
         mdl_rdy_q <= 1'b0;
         mdl_sq_q  <= 1'b0;
         mdl_acc_q <= '0;
      end else begin
         mdl_rdy_q <= 1'b1;
         if (sp_absorb_valid && sp_absorb_ready) begin
            mdl_acc_q <= mdl_acc_q ^ sp_absorb_data;
            if (sp_absorb_last) mdl_sq_q <= 1'b1;
         end
      end
   end

   assign sp_absorb_ready  = mdl_rdy_q;
   assign sp_squeeze_valid = mdl_sq_q;
   assign sp_squeeze_data  = mdl_acc_q ^ {59'b0, sp_rate_words};
   assign sp_busy          = busy_force;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) check("onehot", {63'b0, ($countones(grant) <= 1)}, 64'd1);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_inputs();
      req_valid        = '0;
      req_release      = '0;
      rq_absorb_valid  = '0;
      rq_absorb_data   = '0;
      rq_absorb_last   = '0;
      rq_squeeze_ready = '0;
      busy_force       = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic wait_grant(input string tag, input int idx);
      int n = 0;
      while (grant == '0 && n < 20) begin
         tick();
         n++;
      end
      check(tag, {60'b0, grant}, 64'(1) << idx);
      check({tag, "_idx"}, {62'b0, grant_idx}, 64'(idx));
   endtask

   // Drive one absorb beat from requester own for one cycle.
   task automatic beat(input int own, input logic [63:0] d, input logic last, input logic rel);
      rq_absorb_valid                 = '0;
      rq_absorb_data                  = '0;
      rq_absorb_valid[own]            = 1'b1;
      rq_absorb_data[own*64 +: 64]    = d;
      rq_absorb_last                  = '0;
      rq_absorb_last[own]             = last;
      req_release                     = '0;
      req_release[own]                = rel;
      tick();
      rq_absorb_valid = '0;
      rq_absorb_last  = '0;
      req_release     = '0;
   endtask

   initial begin
      req_rate_words = {RATE_SHA3_512, RATE_SHA3_256, RATE_SHAKE256, RATE_SHAKE128};
      clear_inputs();

      // Reset state
      rst = 1'b1;
      tick();
      tick();
      check("rst_grant", {60'b0, grant}, 64'd0);
      check("rst_idx", {62'b0, grant_idx}, 64'd0);
      check("rst_sp_rst_n", {63'b0, sp_rst_n}, 64'd0);
      check("rst_state", {61'b0, dbg_state}, 64'(ARB_IDLE));
      check("rst_sp_av", {63'b0, sp_absorb_valid}, 64'd0);
      rst = 1'b0;
      tick();
      check("idle_sp_rst_n", {63'b0, sp_rst_n}, 64'd1);

      // 1: single request, clear pulse, 4-cycle grant latency, SHAKE128 digest
      req_valid = 4'b0001;
      tick();
      check("t1_clear_rst_n", {63'b0, sp_rst_n}, 64'd0);
      check("t1_clear_state", {61'b0, dbg_state}, 64'(ARB_CLEAR));
      tick();
      check("t1_wait_rst_n", {63'b0, sp_rst_n}, 64'd1);
      check("t1_c2_grant", {60'b0, grant}, 64'd0);
      tick();
      check("t1_c3_grant", {60'b0, grant}, 64'd0);
      check("t1_c3_rate", {59'b0, sp_rate_words}, 64'd0);
      tick();
      check("t1_c4_grant", {60'b0, grant}, 64'd1);
      check("t1_rate", {59'b0, sp_rate_words}, 64'd21);
      req_valid = '0;
      rq_absorb_valid[0] = 1'b1;
      rq_absorb_data[63:0] = 64'h0123456789abcdef;
      #1;
      check("t1_ready_vec", {60'b0, rq_absorb_ready}, 64'd1);
      check("t1_sp_data", sp_absorb_data, 64'h0123456789abcdef);
      tick();
      rq_absorb_data[63:0] = 64'hffff0000ffff0000;
      rq_absorb_last[0] = 1'b1;
      tick();
      rq_absorb_valid = '0;
      rq_absorb_last  = '0;
      rq_squeeze_ready[0] = 1'b1;
      #1;
      check("t1_sq_valid", {60'b0, rq_squeeze_valid}, 64'd1);
      check("t1_sq_ready", {63'b0, sp_squeeze_ready}, 64'd1);
      check("t1_digest", rq_squeeze_data, 64'hfedc45677654cdfa);
      rq_squeeze_ready = '0;
      req_release[0] = 1'b1;
      tick();
      req_release = '0;
      check("t1_drain", {61'b0, dbg_state}, 64'(ARB_DRAIN));
      check("t1_drain_grant", {60'b0, grant}, 64'd0);
      tick();
      check("t1_idle", {61'b0, dbg_state}, 64'(ARB_IDLE));

      // 2: all requesting, round-robin order 0,1,2,3,0; release on the third beat
      do_reset();
      mon_en = 1'b1;
      req_valid = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         wait_grant($sformatf("t2_grant%0d", g), g % NR);
         beat(g % NR, 64'd1, 1'b0, 1'b0);
         beat(g % NR, 64'd2, 1'b0, 1'b0);
         beat(g % NR, 64'd4, 1'b1, 1'b1);
         check($sformatf("t2_drain%0d", g), {61'b0, dbg_state}, 64'(ARB_DRAIN));
         check($sformatf("t2_lastbeat%0d", g), sp_squeeze_data, 64'd7);
      end
      mon_en = 1'b0;

      // 3: release while busy, drain holds until busy falls; next owner sees a fresh sponge
      do_reset();
      req_valid = 4'b0100;
      wait_grant("t3_grant2", 2);
      req_valid  = 4'b1000;
      busy_force = 1'b1;
      beat(2, 64'hdeadbeefcafef00d, 1'b1, 1'b1);
      check("t3_grant_drop", {60'b0, grant}, 64'd0);
      check("t3_drain", {61'b0, dbg_state}, 64'(ARB_DRAIN));
      tick();
      tick();
      check("t3_drain_hold", {61'b0, dbg_state}, 64'(ARB_DRAIN));
      busy_force = 1'b0;
      tick();
      check("t3_idle", {61'b0, dbg_state}, 64'(ARB_IDLE));
      wait_grant("t3_grant3", 3);
      req_valid = '0;
      beat(3, 64'd0, 1'b1, 1'b0);
      check("t3_empty_digest", rq_squeeze_data, 64'd9);
      check("t3_sq_valid", {60'b0, rq_squeeze_valid}, 64'b1000);

      // 4: non-owner activity is ignored
      do_reset();
      req_valid = 4'b0001;
      wait_grant("t4_grant0", 0);
      req_valid = 4'b0011;
      rq_absorb_valid = 4'b0010;
      rq_absorb_data[127:64] = 64'h1111;
      req_release = 4'b0010;
      #1;
      check("t4_sp_av", {63'b0, sp_absorb_valid}, 64'd0);
      check("t4_rdy1", {63'b0, rq_absorb_ready[1]}, 64'd0);
      check("t4_grant", {60'b0, grant}, 64'd1);
      tick();
      clear_inputs();
      req_valid = 4'b0011;
      #1;
      check("t4_grant_kept", {60'b0, grant}, 64'd1);
      check("t4_owned", {61'b0, dbg_state}, 64'(ARB_OWNED));

      // 5: reset while owned
      do_reset();
      req_valid = 4'b0100;
      wait_grant("t5_grant2", 2);
      check("t5_ptr3", {62'b0, dbg_ptr}, 64'd3);
      rst = 1'b1;
      tick();
      check("t5_grant", {60'b0, grant}, 64'd0);
      check("t5_sp_rst_n", {63'b0, sp_rst_n}, 64'd0);
      check("t5_state", {61'b0, dbg_state}, 64'(ARB_IDLE));
      check("t5_ptr", {62'b0, dbg_ptr}, 64'd0);
      rst = 1'b0;

      // 6: idle owner
      do_reset();
      req_valid = 4'b0001;
      wait_grant("t6_grant0", 0);
      req_valid = '0;
`ifdef KECCAK_ARB_TIMEOUT_EN
      check("t6_no_evt", {63'b0, timeout_evt}, 64'd0);
      for (int i = 0; i < 15; i++) tick();
      check("t6_evt", {63'b0, timeout_evt}, 64'd1);
      check("t6_still_owned", {60'b0, grant}, 64'd1);
      tick();
      check("t6_evt_pulse", {63'b0, timeout_evt}, 64'd0);
      check("t6_drain", {61'b0, dbg_state}, 64'(ARB_DRAIN));
`else
      for (int i = 0; i < 40; i++) tick();
      check("t6_hold_grant", {60'b0, grant}, 64'd1);
      check("t6_hold_state", {61'b0, dbg_state}, 64'(ARB_OWNED));
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
